// File: rtl/sec_pkg.sv
// Shared security-path types and constants for key authentication and the datapath it feeds.
package sec_pkg;

  localparam int unsigned KEY_W = 16;

  localparam logic [KEY_W-1:0] KEY_NONE           = 16'h0000;
  localparam logic [KEY_W-1:0] UNLOCK_KEY_DEFAULT = 16'h0032;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    SESSION = 2'd2,
    LOCKOUT = 2'd3
  } key_auth_state_t;

  // Captured key attempt: target 0 = memory-write path, 1 = register-read path.
  typedef struct packed {
    logic             target;
    logic [KEY_W-1:0] key;
  } key_attempt_t;

endpackage

// File: rtl/key_auth_ctrl_if.sv
// Key-attempt and access-request handshakes between a requester and key_auth_ctrl.
interface key_auth_ctrl_if #(
  parameter int unsigned ADDR_W = 10
);
  import sec_pkg::*;

  logic             key_valid;
  logic [KEY_W-1:0] key_in;
  logic             key_target;
  logic             key_ready;
  logic             req_valid;
  logic             req_write;
  logic [ADDR_W-1:0] req_addr;
  logic             req_ready;

  modport master (
    output key_valid, key_in, key_target, req_valid, req_write, req_addr,
    input  key_ready, req_ready
  );

  modport slave (
    input  key_valid, key_in, key_target, req_valid, req_write, req_addr,
    output key_ready, req_ready
  );

endinterface

// File: rtl/sec_down_timer.sv
// Loadable down-counter that stops at zero; expire flags the enabled 1 -> 0 step.
module sec_down_timer #(
  parameter int unsigned LOAD_VAL = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire_c
);

  localparam int unsigned W = $clog2(LOAD_VAL) + 1;

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= W'(LOAD_VAL);
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_expire_c = i_en && (r_count == W'(1));

endmodule

// File: rtl/key_auth_ctrl.sv
// Key authentication, timed session and lockout gating for the security datapath.
// Optional audit counters are built when KEY_AUTH_AUDIT_EN is defined.
module key_auth_ctrl
  import sec_pkg::*;
#(
  parameter logic [KEY_W-1:0] UNLOCK_KEY     = UNLOCK_KEY_DEFAULT,
  parameter int unsigned      MAX_FAILS      = 3,
  parameter int unsigned      LOCKOUT_CYCLES = 256,
  parameter int unsigned      SESSION_CYCLES = 1024,
  parameter int unsigned      ADDR_W         = 10
) (
  input  logic               clk,
  input  logic               rst,
  key_auth_ctrl_if.slave     bus,
  output logic [KEY_W-1:0]   key_access_mem,
  output logic [KEY_W-1:0]   key_access_reg,
  output logic [ADDR_W-1:0]  write_address,
  output logic [ADDR_W-1:0]  read_address,
  output logic               locked,
  output logic [1:0]         fail_count
`ifdef KEY_AUTH_AUDIT_EN
  ,
  output logic [15:0]        audit_fail_total,
  output logic [7:0]         audit_lockouts
`endif
);

  localparam logic [1:0] MAX_F = 2'(MAX_FAILS);

  key_auth_state_t   r_state, w_state_nxt;
  key_attempt_t      r_attempt;
  logic              r_grant_mem, r_grant_reg;
  logic              w_grant_mem_nxt, w_grant_reg_nxt;
  logic [1:0]        r_fail, w_fail_nxt, w_fail_inc;
  logic              r_locked;
  logic [KEY_W-1:0]  r_access_mem, r_access_reg;
  logic [ADDR_W-1:0] r_wr_addr, r_rd_addr;
  logic              w_key_ready, w_req_ready, w_key_hs, w_req_hs, w_match;
  logic              w_sess_load, w_lock_load, w_sess_expire, w_lock_expire;

  assign w_key_ready = (r_state == IDLE) || (r_state == SESSION);
  assign w_req_ready = (r_state == SESSION) && (bus.req_write ? r_grant_mem : r_grant_reg);
  assign w_key_hs    = bus.key_valid && w_key_ready;
  assign w_req_hs    = bus.req_valid && w_req_ready;
  assign w_match     = (r_attempt.key == UNLOCK_KEY);
  assign w_fail_inc  = (r_fail == MAX_F) ? r_fail : r_fail + 2'd1;

  sec_down_timer #(.LOAD_VAL(SESSION_CYCLES)) u_session_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_sess_load),
    .i_en       (r_state == SESSION),
    .o_expire_c (w_sess_expire)
  );

  sec_down_timer #(.LOAD_VAL(LOCKOUT_CYCLES)) u_lockout_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_lock_load),
    .i_en       (r_state == LOCKOUT),
    .o_expire_c (w_lock_expire)
  );

  // Next-state, grant and fail-count decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_grant_mem_nxt = r_grant_mem;
    w_grant_reg_nxt = r_grant_reg;
    w_fail_nxt      = r_fail;
    w_sess_load     = 1'b0;
    w_lock_load     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_key_hs) w_state_nxt = CHECK;
      end
      CHECK: begin
        if (w_match) begin
          if (r_attempt.target) w_grant_reg_nxt = 1'b1;
          else                  w_grant_mem_nxt = 1'b1;
          w_sess_load = 1'b1;
          w_fail_nxt  = 2'd0;
          w_state_nxt = SESSION;
        end else begin
          w_grant_mem_nxt = 1'b0;
          w_grant_reg_nxt = 1'b0;
          w_fail_nxt      = w_fail_inc;
          if (w_fail_inc == MAX_F) begin
            w_lock_load = 1'b1;
            w_state_nxt = LOCKOUT;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      SESSION: begin
        // Expiry clears grants even when a new attempt is accepted the same cycle.
        if (w_sess_expire) begin
          w_grant_mem_nxt = 1'b0;
          w_grant_reg_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end
        if (w_key_hs) w_state_nxt = CHECK;
      end
      LOCKOUT: begin
        if (w_lock_expire) begin
          w_fail_nxt  = 2'd0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_attempt    <= '0;
      r_grant_mem  <= 1'b0;
      r_grant_reg  <= 1'b0;
      r_fail       <= 2'd0;
      r_locked     <= 1'b0;
      r_access_mem <= KEY_NONE;
      r_access_reg <= KEY_NONE;
      r_wr_addr    <= '0;
      r_rd_addr    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant_mem  <= w_grant_mem_nxt;
      r_grant_reg  <= w_grant_reg_nxt;
      r_fail       <= w_fail_nxt;
      r_locked     <= (w_state_nxt == LOCKOUT);
      r_access_mem <= w_grant_mem_nxt ? UNLOCK_KEY : KEY_NONE;
      r_access_reg <= w_grant_reg_nxt ? UNLOCK_KEY : KEY_NONE;
      if (w_key_hs) begin
        r_attempt.key    <= bus.key_in;
        r_attempt.target <= bus.key_target;
      end
      if (w_req_hs && bus.req_write)  r_wr_addr <= bus.req_addr;
      if (w_req_hs && !bus.req_write) r_rd_addr <= bus.req_addr;
    end
  end

`ifdef KEY_AUTH_AUDIT_EN
  logic        w_mismatch;
  logic [15:0] r_audit_fail;
  logic [7:0]  r_audit_lock;

  assign w_mismatch = (r_state == CHECK) && !w_match;

  // Saturating audit counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_audit_fail <= '0;
      r_audit_lock <= '0;
    end else begin
      if (w_mismatch && (r_audit_fail != 16'hFFFF)) r_audit_fail <= r_audit_fail + 16'd1;
      if (w_lock_load && (r_audit_lock != 8'hFF))   r_audit_lock <= r_audit_lock + 8'd1;
    end
  end

  assign audit_fail_total = r_audit_fail;
  assign audit_lockouts   = r_audit_lock;
`endif

  assign bus.key_ready  = w_key_ready;
  assign bus.req_ready  = w_req_ready;
  assign key_access_mem = r_access_mem;
  assign key_access_reg = r_access_reg;
  assign write_address  = r_wr_addr;
  assign read_address   = r_rd_addr;
  assign locked         = r_locked;
  assign fail_count     = r_fail;

endmodule

// File: tb/tb_key_auth_ctrl.sv
// Directed self-checking bench for key_auth_ctrl with a 16-cycle session.
module tb_key_auth_ctrl;

  localparam int unsigned ADDR_W = 10;

  logic clk = 1'b0;
  logic rst;
  logic [15:0]       key_access_mem, key_access_reg;
  logic [ADDR_W-1:0] write_address, read_address;
  logic              locked;
  logic [1:0]        fail_count;
`ifdef KEY_AUTH_AUDIT_EN
  logic [15:0]       audit_fail_total;
  logic [7:0]        audit_lockouts;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_lock;

  key_auth_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  key_auth_ctrl #(
    .UNLOCK_KEY     (16'h0032),
    .MAX_FAILS      (3),
    .LOCKOUT_CYCLES (256),
    .SESSION_CYCLES (16),
    .ADDR_W         (ADDR_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .key_access_mem (key_access_mem),
    .key_access_reg (key_access_reg),
    .write_address  (write_address),
    .read_address   (read_address),
    .locked         (locked),
    .fail_count     (fail_count)
`ifdef KEY_AUTH_AUDIT_EN
    ,
    .audit_fail_total (audit_fail_total),
    .audit_lockouts   (audit_lockouts)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one key for one cycle; on return the attempt has been sampled.
  task automatic send_key(input logic [15:0] k, input logic tgt);
    bus.key_valid  = 1'b1;
    bus.key_in     = k;
    bus.key_target = tgt;
    tick();
    bus.key_valid  = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem"},   32'(key_access_mem), 32'h0);
    chk({tag, "_reg"},   32'(key_access_reg), 32'h0);
    chk({tag, "_waddr"}, 32'(write_address),  32'h0);
    chk({tag, "_raddr"}, 32'(read_address),   32'h0);
    chk({tag, "_lock"},  32'(locked),         32'h0);
    chk({tag, "_fail"},  32'(fail_count),     32'h0);
    chk({tag, "_kready"}, 32'(bus.key_ready), 32'h1);
`ifdef KEY_AUTH_AUDIT_EN
    chk({tag, "_afail"}, 32'(audit_fail_total), 32'h0);
    chk({tag, "_alock"}, 32'(audit_lockouts),   32'h0);
`endif
  endtask

  initial begin
    rst            = 1'b1;
    bus.key_valid  = 1'b0;
    bus.key_in     = 16'h0;
    bus.key_target = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    tick();
    tick();
    rst = 1'b0;
    chk_all_zero("reset");
    chk("reset_rready", 32'(bus.req_ready), 32'h0);

    // Memory-path grant, two cycles after the handshake.
    send_key(16'h0032, 1'b0);
    chk("check_kready", 32'(bus.key_ready), 32'h0);
    chk("check_mem_early", 32'(key_access_mem), 32'h0);
    tick();
    chk("grant_mem", 32'(key_access_mem), 32'h0032);
    chk("grant_reg_idle", 32'(key_access_reg), 32'h0);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 10'd200;
    #1;
    chk("wr_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 1'b0;
    chk("wr_addr", 32'(write_address), 32'd200);

    // Read blocked until the register path is granted.
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 10'd7;
    #1;
    chk("rd_blocked", 32'(bus.req_ready), 32'h0);
    tick();
    bus.req_valid = 1'b0;
    chk("rd_addr_hold", 32'(read_address), 32'h0);
    send_key(16'h0032, 1'b1);
    tick();
    chk("both_mem", 32'(key_access_mem), 32'h0032);
    chk("both_reg", 32'(key_access_reg), 32'h0032);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 10'd5;
    #1;
    chk("rd_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 1'b0;
    chk("rd_addr", 32'(read_address), 32'd5);
    chk("wr_addr_keep", 32'(write_address), 32'd200);

    // Mismatch in session drops both grants.
    send_key(16'h1234, 1'b0);
    tick();
    chk("mm_mem", 32'(key_access_mem), 32'h0);
    chk("mm_reg", 32'(key_access_reg), 32'h0);
    chk("mm_fail", 32'(fail_count), 32'd1);
    chk("mm_idle", 32'(bus.key_ready), 32'h1);
    chk("mm_rd_addr", 32'(read_address), 32'd5);

    // Clear the count, then three bad keys into lockout.
    send_key(16'h0032, 1'b0);
    tick();
    chk("clr_fail", 32'(fail_count), 32'd0);
    send_key(16'h0031, 1'b0);
    tick();
    chk("lk_fail1", 32'(fail_count), 32'd1);
    send_key(16'h0031, 1'b0);
    tick();
    chk("lk_fail2", 32'(fail_count), 32'd2);
    chk("lk_unlocked", 32'(locked), 32'h0);
    send_key(16'h0031, 1'b0);
    tick();
    chk("lk_locked", 32'(locked), 32'h1);
    chk("lk_fail3", 32'(fail_count), 32'd3);
    n_lock = 1;
    bus.key_valid = 1'b1; bus.key_in = 16'h0032; bus.key_target = 1'b0;
    #1;
    chk("lk_kready", 32'(bus.key_ready), 32'h0);
    tick();
    bus.key_valid = 1'b0;
    if (locked) n_lock++;
    chk("lk_no_grant", 32'(key_access_mem), 32'h0);
    for (int i = 0; i < 400; i++) begin
      tick();
      if (!locked) break;
      n_lock++;
    end
    chk("lk_cycles", 32'(n_lock), 32'd256);
    chk("lk_exit_fail", 32'(fail_count), 32'd0);
    chk("lk_exit_idle", 32'(bus.key_ready), 32'h1);

    // Expiry with a handshake on the expiry cycle.
    send_key(16'h0032, 1'b0);
    tick();
    chk("exp_grant", 32'(key_access_mem), 32'h0032);
    for (int i = 0; i < 15; i++) tick();
    chk("exp_hold15", 32'(key_access_mem), 32'h0032);
    send_key(16'h0032, 1'b1);
    chk("exp_mem_drop", 32'(key_access_mem), 32'h0);
    chk("exp_reg_drop", 32'(key_access_reg), 32'h0);
    chk("exp_check", 32'(bus.key_ready), 32'h0);
    tick();
    chk("regrant_reg", 32'(key_access_reg), 32'h0032);
    chk("regrant_mem", 32'(key_access_mem), 32'h0);

    // Plain expiry returns to IDLE; addresses persist.
    for (int i = 0; i < 15; i++) tick();
    chk("exp2_hold15", 32'(key_access_reg), 32'h0032);
    tick();
    chk("exp2_drop", 32'(key_access_reg), 32'h0);
    chk("exp2_idle", 32'(bus.key_ready), 32'h1);
    chk("exp2_raddr", 32'(read_address), 32'd5);
    chk("exp2_waddr", 32'(write_address), 32'd200);

    // Reset mid-session.
    send_key(16'h0032, 1'b1);
    tick();
    chk("rs_pre_reg", 32'(key_access_reg), 32'h0032);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("rst_sess");

    // Reset mid-lockout.
    send_key(16'h0031, 1'b0);
    tick();
    send_key(16'h0031, 1'b0);
    tick();
    send_key(16'h0031, 1'b0);
    tick();
    tick();
    tick();
    chk("rl_locked", 32'(locked), 32'h1);
`ifdef KEY_AUTH_AUDIT_EN
    chk("rl_afail", 32'(audit_fail_total), 32'd3);
    chk("rl_alock", 32'(audit_lockouts), 32'd1);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("rst_lock");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
